// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 4-digit hex display scanner.
package seg_pkg;

    localparam int          NUM_DIGITS      = 4;
    localparam int          IDX_W           = $clog2(NUM_DIGITS);
    localparam logic [3:0]  ANODE_OFF       = 4'b1111;
    localparam int          CLK_DIV_DEFAULT = 50000;

    typedef logic [IDX_W-1:0] digit_idx_t;

    // Digit k is lit when any digit at or left of k is nonzero; digit 0 always.
    function automatic logic digit_lit(input logic [15:0] value, input digit_idx_t idx);
        logic lit;
        lit = 1'b1;
        case (idx)
            2'd3:    lit = (value[15:12] != 4'h0);
            2'd2:    lit = (value[15:8] != 8'h00);
            2'd1:    lit = (value[15:4] != 12'h000);
            default: lit = 1'b1;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/seg_scan_mux_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks.
module tick_gen
    import seg_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for a 4-digit hex display with frame-aligned
// double buffering and leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        en,
    input  logic        blank_lz,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic        frame_start
);

    logic        tick;
    logic        wrap;
    digit_idx_t  idx;
    logic [15:0] display;
    logic [15:0] staging;
    logic        pending;
    logic [3:0]  nib_sel;
    logic [3:0]  an_sel;
    logic        lit;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

    always_comb begin
        nib_sel = display[{idx, 2'b00} +: 4];
        lit     = !blank_lz || digit_lit(display, idx);
        an_sel  = ANODE_OFF;
        if (en && lit) begin
            an_sel = ~(4'b0001 << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            display     <= 16'h0000;
            staging     <= 16'h0000;
            pending     <= 1'b0;
            nib         <= 4'h0;
            an          <= ANODE_OFF;
            frame_start <= 1'b0;
        end else begin
            if (tick) begin
                idx <= idx + digit_idx_t'(1);
            end
            frame_start <= wrap;
            // Display only moves at a frame boundary; a coincident load bypasses staging.
            if (wrap) begin
                if (load) begin
                    display <= din;
                end else if (pending) begin
                    display <= staging;
                end
                pending <= 1'b0;
            end else if (load) begin
                staging <= din;
                pending <= 1'b1;
            end
            nib <= nib_sel;
            an  <= an_sel;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: spec vectors, corner sequences and
// randomized traffic against a slot/frame-level reference model.
module tb_seg_scan_mux;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        en;
    logic        blank_lz;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .din         (din),
        .en          (en),
        .blank_lz    (blank_lz),
        .nib         (nib),
        .an          (an),
        .frame_start (frame_start)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: cycles since reset, shown value, staged value.
    int          t = 0;
    logic [15:0] mdisp = 16'h0;
    logic [15:0] mstage = 16'h0;
    logic        mpend = 1'b0;
    logic        mvalid = 1'b0;
    int          fs_count = 0;
    logic        a_seen = 1'b0;

    typedef struct {
        logic [15:0] din;
        logic        blank;
        logic        en;
        logic [15:0] ean;
        logic [15:0] enib;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int          slot;
        logic        wrap;
        logic        lit;
        logic        r;
        logic [3:0]  enib;
        logic [3:0]  ean;
        logic        efs;
        slot = (t / CLK_DIV) % 4;
        wrap = ((t % CLK_DIV) == CLK_DIV - 1) && (slot == 3);
        r    = rst;
        if (r) begin
            enib = 4'h0;
            ean  = 4'hF;
            efs  = 1'b0;
        end else begin
            enib = 4'((mdisp >> (4 * slot)) & 16'hF);
            lit  = !blank_lz || (slot == 0) || ((mdisp >> (4 * slot)) != 16'h0);
            ean  = (en && lit) ? ~(4'(1) << slot) : 4'hF;
            efs  = wrap;
        end
        @(posedge clk);
        #1;
        if (r || mvalid) begin
            chk("model_nib", {12'h0, nib}, {12'h0, enib});
            chk("model_an", {12'h0, an}, {12'h0, ean});
            chk("model_frame_start", {15'h0, frame_start}, {15'h0, efs});
        end
        if (nib === 4'hA) a_seen = 1'b1;
        if (frame_start === 1'b1) fs_count++;
        if (r) begin
            t      = 0;
            mdisp  = 16'h0;
            mstage = 16'h0;
            mpend  = 1'b0;
            mvalid = 1'b1;
        end else begin
            if (wrap) begin
                if (load) mdisp = din;
                else if (mpend) mdisp = mstage;
                mpend = 1'b0;
            end else if (load) begin
                mstage = din;
                mpend  = 1'b1;
            end
            t++;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        din  = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("frame_wait", {15'h0, frame_start}, 16'h1);
    endtask

    // Called in the frame_start cycle; checks the 16 cycles of that frame.
    task automatic check_frame(input string name, input logic [15:0] ean, input logic [15:0] enib);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                step();
                chk({name, "_an"}, {12'h0, an}, {12'h0, ean[4*s +: 4]});
                chk({name, "_nib"}, {12'h0, nib}, {12'h0, enib[4*s +: 4]});
            end
        end
    endtask

    initial begin
        int fs0;
        tbl[0] = '{16'h1234, 1'b0, 1'b1, 16'h7BDE, 16'h1234};
        tbl[1] = '{16'h0040, 1'b1, 1'b1, 16'hFFDE, 16'h0040};
        tbl[2] = '{16'h0000, 1'b1, 1'b1, 16'hFFFE, 16'h0000};
        tbl[3] = '{16'h0100, 1'b1, 1'b1, 16'hFBDE, 16'h0100};
        tbl[4] = '{16'h1234, 1'b0, 1'b0, 16'hFFFF, 16'h1234};
        tbl[5] = '{16'h0000, 1'b0, 1'b1, 16'h7BDE, 16'h0000};
        tbl[6] = '{16'h0005, 1'b1, 1'b1, 16'hFFFE, 16'h0005};
        tbl[7] = '{16'hF000, 1'b1, 1'b1, 16'h7BDE, 16'hF000};

        rst = 1'b1; load = 1'b0; din = 16'h0; en = 1'b1; blank_lz = 1'b0;
        step(); step();
        chk("reset_an", {12'h0, an}, 16'h000F);
        chk("reset_nib", {12'h0, nib}, 16'h0000);
        chk("reset_fs", {15'h0, frame_start}, 16'h0);
        rst = 1'b0;
        step();
        chk("first_slot_an", {12'h0, an}, 16'h000E);
        chk("first_slot_nib", {12'h0, nib}, 16'h0000);

        foreach (tbl[i]) begin
            en       = tbl[i].en;
            blank_lz = tbl[i].blank;
            do_load(tbl[i].din);
            wait_frame();
            check_frame($sformatf("vec%0d", i), tbl[i].ean, tbl[i].enib);
        end

        // Load on the wrap tick goes straight to display; stale staging must not follow.
        en = 1'b1; blank_lz = 1'b0;
        wait_frame();
        repeat (4) step();
        do_load(16'h1111);
        repeat (10) step();
        do_load(16'h5678);
        chk("wrap_load_fs", {15'h0, frame_start}, 16'h1);
        check_frame("wrap_load_f1", 16'h7BDE, 16'h5678);
        check_frame("wrap_load_f2", 16'h7BDE, 16'h5678);

        // Two loads in one frame: last wins, first never shown.
        a_seen = 1'b0;
        repeat (3) step();
        do_load(16'hAAAA);
        repeat (4) step();
        do_load(16'hBBBB);
        wait_frame();
        fs0 = fs_count;
        check_frame("last_wins_f1", 16'h7BDE, 16'hBBBB);
        check_frame("last_wins_f2", 16'h7BDE, 16'hBBBB);
        chk("no_a_shown", {15'h0, a_seen}, 16'h0);
        chk("fs_per_frame", 16'(fs_count - fs0), 16'h2);

        // Display disable mid-frame, scan keeps going.
        repeat (5) step();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("en_off_an", {12'h0, an}, 16'h000F);
        end
        en = 1'b1;
        step();
        chk("en_resume_an", {12'h0, an}, 16'h0007);
        chk("en_resume_nib", {12'h0, nib}, 16'h000B);

        // Reset during digit 2 with a value pending.
        wait_frame();
        step();
        do_load(16'h9999);
        repeat (7) step();
        rst = 1'b1;
        step();
        chk("rst_mid_an", {12'h0, an}, 16'h000F);
        chk("rst_mid_nib", {12'h0, nib}, 16'h0000);
        rst = 1'b0;
        step();
        chk("rst_mid_slot0", {12'h0, an}, 16'h000E);
        wait_frame();
        check_frame("rst_discard", 16'h7BDE, 16'h0000);

        for (int k = 0; k < 1500; k++) begin
            load = ($urandom % 8) == 0;
            din  = 16'($urandom_range(0, 65535) >> ($urandom % 16));
            if (($urandom % 16) == 0) en = ~en;
            if (($urandom % 16) == 0) blank_lz = ~blank_lz;
            rst = ($urandom % 300) == 0;
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clk cycles per digit slot (minimum 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load  input  1  one-cycle strobe that captures din.
REQ-005 SHALL have port din  input  16  four hex digits; [15:12] is digit 3 (leftmost), [3:0] is digit 0.
REQ-006 SHALL have port en  input  1  display enable; 0 turns all anodes off.
REQ-007 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-008 SHALL have port nib  output  4  current digit nibble, bit 3 MSB, for the downstream 7-segment decoder.
REQ-009 SHALL have port an  output  4  anode selects, active-low, an[k] drives digit k.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-011 SHALL run a prescaler over 0..CLK_DIV-1 and assert an internal tick on the cycle it equals CLK_DIV-1.
REQ-012 SHALL advance the digit index 0->1->2->3->0 on each tick and hold it otherwise.
REQ-013 SHALL treat a tick at index 3 as a wrap and assert frame_start in the following cycle for exactly one cycle.
REQ-014 SHALL keep a display register (shown value) and a staging register with a pending flag.
REQ-015 SHALL, on load without a wrap in the same cycle, write din to staging and set pending.
REQ-016 SHALL, on load while pending is already set, overwrite staging; the last value wins.
REQ-017 SHALL, on a wrap with pending set and no load, copy staging to display and clear pending.
REQ-018 SHALL, on a wrap coinciding with load, write din directly to display and clear pending.
REQ-019 SHALL never change the display register except at a wrap, so no frame mixes two values.
REQ-020 SHALL register nib and an every cycle from the current index and display register, giving one cycle of latency from an index change.
REQ-021 SHALL drive nib with the display nibble selected by the index.
REQ-022 SHALL drive an low only on bit[index] (e.g. index 2 -> 4'b1011), unless the slot is blanked or en=0.
REQ-023 SHALL, when blank_lz=1, blank digit 3 if it is zero, digit 2 if digits 3..2 are zero, and digit 1 if digits 3..1 are zero.
REQ-024 SHALL never blank digit 0.
REQ-025 SHALL drive an=4'b1111 for a blanked slot while nib still carries the nibble.
REQ-026 SHALL, when en=0, drive an=4'b1111 while the prescaler, index and load logic keep running.
REQ-027 SHALL apply en and blank_lz changes one cycle after they occur, mid-slot if needed.

Reset
REQ-028 SHALL, with rst high at a clock edge, set prescaler=0, index=0, display=16'h0000, staging=16'h0000, pending=0, nib=4'h0, an=4'b1111 and frame_start=0 from the next cycle.
REQ-029 SHALL give rst priority over load, tick and wrap; a staged value is discarded.
REQ-030 SHALL, on release of rst, start at digit 0 and show the first slot with display 0000.

Structure
REQ-031 SHALL place NUM_DIGITS=4, ANODE_OFF=4'b1111 and the CLK_DIV default in shared package seg_pkg.
REQ-032 SHALL implement the prescaler as sub-module tick_gen (clk, rst, tick); index, staging, blanking and output registers stay in seg_scan_mux.
REQ-033 SHALL pass nib to the 7-segment decoder unchanged; the decoder's anode outputs are superseded by an.

Verification (CLK_DIV=4)
REQ-034 SHALL cover: rst, en=1, blank_lz=0, load 16'h1234 -> after the next wrap, slots of 4 cycles each show (an,nib) = (1110,4), (1101,3), (1011,2), (0111,1), repeating.
REQ-035 SHALL cover: blank_lz=1, load 16'h0040 -> an=1111 in the digit 3 and digit 2 slots, (1101,4), (1110,0); and load 16'h0000 -> only digit 0 lit, showing 0.
REQ-036 SHALL cover: mid-frame load 16'hAAAA, then 16'hBBBB before the wrap -> the next frame shows BBBB, no A is ever shown, and frame_start pulses once per frame.
REQ-037 SHALL cover: load 16'h5678 on the wrap-tick cycle -> the immediately following frame shows 5678 and pending stays 0.
REQ-038 SHALL cover: en=0 for 10 cycles mid-frame -> an=1111 throughout; after en=1 the scan resumes at the index reached, with no slot restart.
REQ-039 SHALL cover: rst during digit 2 with pending set -> next cycle an=1111, nib=0, index 0, and the staged value never appears.
